updown_count_reg: RTL and testbench
===================================

UPDOWN_COUNT_REG -- requirements
Module: updown_count_reg

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset, named as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.

REQ-002 The module SHALL have the following data and control ports:
- start  input  1  begin a run; loads LoadVal, clears Wrap.
- stop  input  1  abort a run; return to IDLE.
- en  input  1  count-step qualifier in COUNT.
- sel  input  1  direction: 0 = increment (take S), 1 = decrement (take D).
- LoadVal  input  4  start value.
- Limit  input  4  terminal value.
- S  input  4  incrementer result of A.
- CoutInc  input  1  incrementer carry-out.
- D  input  4  decrementer result of A.
- CoutDec  input  1  decrementer borrow-out.
- A  output  4  registered count; drives the inc/dec stage operand.
- Busy  output  1  high in COUNT.
- Done  output  1  one-cycle pulse on reaching Limit.
- Wrap  output  1  sticky flag: a wrap occurred during this run.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, COUNT, HOLD.
REQ-004 In IDLE with start=1, the module SHALL load A<=LoadVal, set Wrap<=0 and move to COUNT on the next edge.
REQ-005 In COUNT with en=1, the module SHALL update A<=S when sel=0 and A<=D when sel=1, one clock of latency per step.
REQ-006 In COUNT with en=0, A SHALL hold its value.
REQ-007 A step whose selected carry (CoutInc for sel=0, CoutDec for sel=1) is 1 SHALL set Wrap<=1 in the same edge as the A update.
REQ-008 When a COUNT step produces a next A equal to Limit, the module SHALL assert Done for exactly that one cycle after the edge and move to HOLD.
REQ-009 If LoadVal equals Limit at start, the module SHALL still enter COUNT, and the step that returns A to Limit SHALL raise Done; no Done SHALL be raised at load.
REQ-010 HOLD SHALL keep A and Wrap stable and return to IDLE on the next edge.
REQ-011 stop=1 in COUNT or HOLD SHALL move the FSM to IDLE on the next edge with A unchanged and no Done.
REQ-012 stop SHALL have priority over start, en and the Limit match when asserted together.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 Busy SHALL equal 1 only while the state is COUNT.
REQ-015 The module SHALL not check the S and D inputs; they are combinational functions of A supplied by the upstream stage.
REQ-016 A change of sel between steps SHALL take effect on the next enabled step.

Reset
REQ-017 rst=1 SHALL immediately force state=IDLE, A=0000, Busy=0, Done=0 and Wrap=0, independent of clk.
REQ-018 rst asserted mid-run SHALL discard the run; after release, the module SHALL wait in IDLE for start.

Configuration
REQ-019 Macro UDC_SATURATE_EN: when defined, a step whose selected carry is 1 SHALL leave A unchanged (saturate at 1111 up / 0000 down) and still set Wrap.
REQ-020 When UDC_SATURATE_EN is undefined, A SHALL take the wrapped S or D value (1111->0000 up, 0000->1111 down).

Verification
REQ-021 Scenario: LoadVal=0011, Limit=0110, sel=0, en=1, start pulse -> A=0100, 0101, 0110; Done high for one cycle with A=0110; Wrap=0; Busy falls.
REQ-022 Scenario: LoadVal=0001, Limit=1110, sel=1 -> A=0000, then 1111 with Wrap=1 (macro off); with UDC_SATURATE_EN, A stays 0000, Wrap=1 and Done never fires.
REQ-023 Scenario: en toggled 1,0,0,1 in COUNT from 0101, sel=0 -> A=0110, 0110, 0110, 0111.
REQ-024 Scenario: start and stop asserted together in COUNT -> next state IDLE, A held, no Done.
REQ-025 Scenario: rst pulsed between clock edges at A=1010 -> A=0000, Busy=0 and Wrap=0 before the next edge.
REQ-026 Scenario: LoadVal=Limit=1000, sel=0 -> Done fires only after 16 steps, with Wrap=1 (macro off).

Source files
------------

// File: rtl/updown_count_reg_if.sv
// Bus bundle for updown_count_reg: run control, operands from the external
// inc/dec stage, and the registered count and status flags.
interface updown_count_reg_if;
  logic       start;
  logic       stop;
  logic       en;
  logic       sel;
  logic [3:0] LoadVal;
  logic [3:0] Limit;
  logic [3:0] S;
  logic       CoutInc;
  logic [3:0] D;
  logic       CoutDec;
  logic [3:0] A;
  logic       Busy;
  logic       Done;
  logic       Wrap;

  modport master (
    output start, stop, en, sel, LoadVal, Limit, S, CoutInc, D, CoutDec,
    input  A, Busy, Done, Wrap
  );

  modport slave (
    input  start, stop, en, sel, LoadVal, Limit, S, CoutInc, D, CoutDec,
    output A, Busy, Done, Wrap
  );
endinterface

// File: rtl/updown_count_reg.sv
// Up/down count register fed by an external incrementer/decrementer stage.
// Optional macro UDC_SATURATE_EN: a carrying step holds A instead of wrapping.
module updown_count_reg (
  input  logic              clk,
  input  logic              rst,
  updown_count_reg_if.slave bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic [3:0] step_val;
  logic       step_carry;
  logic [3:0] step_next;

  // Pick the operand produced by the upstream stage for the current direction.
  always_comb begin
    step_val   = bus.sel ? bus.D : bus.S;
    step_carry = bus.sel ? bus.CoutDec : bus.CoutInc;
`ifdef UDC_SATURATE_EN
    step_next  = step_carry ? a_q : step_val;
`else
    step_next  = step_val;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    done_d  = 1'b0;
    wrap_d  = wrap_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.LoadVal;
          wrap_d  = 1'b0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // stop outranks the step and the Limit match
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.en) begin
          a_d = step_next;
          if (step_carry) wrap_d = 1'b1;
          if (step_next == bus.Limit) begin
            done_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.Busy = (state_q == COUNT);
  assign bus.Done = done_q;
  assign bus.Wrap = wrap_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_updown_count_reg.sv
// Table-driven bench for updown_count_reg with a behavioural inc/dec stage
// and a scoreboard queue of expected {A, Busy, Done, Wrap, state}.
module tb_updown_count_reg;

`ifdef UDC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int W = 9;

  logic       clk;
  logic       rst;
  logic       ov;
  logic [1:0] dbg_state;

  updown_count_reg_if bus ();

  updown_count_reg dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // Upstream stage; ov forces a bogus S to show the DUT takes S as given.
  assign bus.S       = ov ? 4'hB : bus.A + 4'd1;
  assign bus.CoutInc = ov ? 1'b0 : (bus.A == 4'hF);
  assign bus.D       = bus.A - 4'd1;
  assign bus.CoutDec = (bus.A == 4'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, en, sel, ovr;
    logic [3:0] lv, lim;
    logic [3:0] a;
    logic       busy, done, wrap;
    logic [1:0] state;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic row(input logic st, sp, en, sel, ovr, input logic [3:0] lv, lim,
                     input logic [3:0] a, input logic busy, done, wrap,
                     input logic [1:0] state);
    vec_t v;
    v.st = st; v.sp = sp; v.en = en; v.sel = sel; v.ovr = ovr;
    v.lv = lv; v.lim = lim; v.a = a;
    v.busy = busy; v.done = done; v.wrap = wrap; v.state = state;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input string fld,
                     input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", name, fld, act, expv);
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    cmp(name, "A",     bus.A,                e[8:5]);
    cmp(name, "Busy",  {3'b0, bus.Busy},     {3'b0, e[4]});
    cmp(name, "Done",  {3'b0, bus.Done},     {3'b0, e[3]});
    cmp(name, "Wrap",  {3'b0, bus.Wrap},     {3'b0, e[2]});
    cmp(name, "state", {2'b0, dbg_state},    {2'b0, e[1:0]});
  endtask

  task automatic drive(input logic st, sp, en, sel, ovr, input logic [3:0] lv, lim);
    bus.start = st; bus.stop = sp; bus.en = en; bus.sel = sel; ov = ovr;
    bus.LoadVal = lv; bus.Limit = lim;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v.st, v.sp, v.en, v.sel, v.ovr, v.lv, v.lim);
    exp_q.push_back({v.a, v.busy, v.done, v.wrap, v.state});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic step(input logic st, sp, en, sel, input logic [3:0] lv, lim,
                      input logic [3:0] a, input logic busy, done, wrap,
                      input logic [1:0] state, input string name);
    vec_t v;
    v.st = st; v.sp = sp; v.en = en; v.sel = sel; v.ovr = 1'b0;
    v.lv = lv; v.lim = lim; v.a = a;
    v.busy = busy; v.done = done; v.wrap = wrap; v.state = state;
    apply(v, name);
  endtask

  initial begin
    // st sp en sel ov  lv   lim   A    busy done wrap state
    row(1,0,0,0,0, 4'h3, 4'h6, 4'h3, 1,0,0, 2'd1);   // load
    row(0,0,1,0,0, 4'h3, 4'h6, 4'h4, 1,0,0, 2'd1);
    row(0,0,1,0,0, 4'h3, 4'h6, 4'h5, 1,0,0, 2'd1);
    row(0,0,1,0,0, 4'h3, 4'h6, 4'h6, 0,1,0, 2'd2);   // Limit reached
    row(0,0,1,0,0, 4'h3, 4'h6, 4'h6, 0,0,0, 2'd0);   // HOLD -> IDLE
    row(0,0,1,0,0, 4'h3, 4'h6, 4'h6, 0,0,0, 2'd0);   // idle waits for start
    row(1,0,0,0,0, 4'h5, 4'hA, 4'h5, 1,0,0, 2'd1);
    row(0,0,1,0,0, 4'h5, 4'hA, 4'h6, 1,0,0, 2'd1);   // en 1,0,0,1
    row(0,0,0,0,0, 4'h5, 4'hA, 4'h6, 1,0,0, 2'd1);
    row(0,0,0,0,0, 4'h5, 4'hA, 4'h6, 1,0,0, 2'd1);
    row(0,0,1,0,0, 4'h5, 4'hA, 4'h7, 1,0,0, 2'd1);
    row(1,1,1,0,0, 4'h2, 4'hA, 4'h7, 0,0,0, 2'd0);   // start+stop
    row(1,0,0,0,0, 4'h9, 4'hA, 4'h9, 1,0,0, 2'd1);
    row(0,1,1,0,0, 4'h9, 4'hA, 4'h9, 0,0,0, 2'd0);   // stop beats Limit match
    row(1,0,0,0,0, 4'h2, 4'h4, 4'h2, 1,0,0, 2'd1);
    row(1,0,1,0,0, 4'hC, 4'h4, 4'h3, 1,0,0, 2'd1);   // start ignored in COUNT
    row(0,0,1,1,0, 4'hC, 4'h4, 4'h2, 1,0,0, 2'd1);   // direction change
    row(0,0,1,0,0, 4'hC, 4'h4, 4'h3, 1,0,0, 2'd1);
    row(0,0,1,0,0, 4'hC, 4'h4, 4'h4, 0,1,0, 2'd2);
    row(0,1,0,0,0, 4'hC, 4'h4, 4'h4, 0,0,0, 2'd0);   // stop in HOLD
    row(1,0,0,0,0, 4'h2, 4'hF, 4'h2, 1,0,0, 2'd1);
    row(0,0,1,0,1, 4'h2, 4'hF, 4'hB, 1,0,0, 2'd1);   // S taken verbatim
    row(0,1,0,0,0, 4'h2, 4'hF, 4'hB, 0,0,0, 2'd0);
    row(1,0,0,1,0, 4'h1, 4'hE, 4'h1, 1,0,0, 2'd1);   // down-wrap run
    row(0,0,1,1,0, 4'h1, 4'hE, 4'h0, 1,0,0, 2'd1);
    row(0,0,1,1,0, 4'h1, 4'hE, SAT ? 4'h0 : 4'hF, 1,0,1, 2'd1);
    row(0,0,1,1,0, 4'h1, 4'hE, SAT ? 4'h0 : 4'hE, SAT, !SAT, 1, SAT ? 2'd1 : 2'd2);
    row(0,0,1,1,0, 4'h1, 4'hE, SAT ? 4'h0 : 4'hE, SAT, 0, 1, SAT ? 2'd1 : 2'd0);
    row(0,1,0,1,0, 4'h1, 4'hE, SAT ? 4'h0 : 4'hE, 0,0,1, 2'd0);
    row(1,0,0,0,0, 4'h8, 4'h8, 4'h8, 1,0,0, 2'd1);   // LoadVal == Limit: no Done

    drive(0, 0, 0, 0, 0, 4'h0, 4'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({4'h0, 1'b0, 1'b0, 1'b0, 2'd0});
    check_out("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Full lap from Limit back to Limit.
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] ea;
      logic       last;
      last = (i == 16) && !SAT;
      if (SAT) ea = (8 + i > 15) ? 4'hF : 4'(8 + i);
      else     ea = 4'(8 + i);
      step(0, 0, 1, 0, 4'h8, 4'h8, ea, !last, last, (i >= 8), last ? 2'd2 : 2'd1,
           $sformatf("lap%0d", i));
    end
    step(0, 1, 0, 0, 4'h8, 4'h8, SAT ? 4'hF : 4'h8, 0, 0, 1, 2'd0, "lap_end");

    // Asynchronous reset mid-run with Wrap set.
    step(1, 0, 0, 0, 4'hF, 4'h5, 4'hF, 1, 0, 0, 2'd1, "rst_load");
    step(0, 0, 1, 0, 4'hF, 4'h5, SAT ? 4'hF : 4'h0, 1, 0, 1, 2'd1, "rst_wrap");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back({4'h0, 1'b0, 1'b0, 1'b0, 2'd0});
    check_out("async_rst");
    #1;
    rst = 1'b0;
    step(0, 0, 1, 0, 4'hF, 4'h5, 4'h0, 0, 0, 0, 2'd0, "post_rst");
    step(1, 0, 0, 0, 4'hA, 4'h5, 4'hA, 1, 0, 0, 2'd1, "restart");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back({4'h0, 1'b0, 1'b0, 1'b0, 2'd0});
    check_out("async_rst_a");
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
